emax_blk_arb: RTL and testbench

//  Block-granular round-robin arbiter sharing one find_emax instance between N fp streams.

---
 rtl/emax_pkg.sv | 17 +
 rtl/rvfifo_cc.sv | 62 ++++++
 rtl/emax_blk_arb.sv | 112 +++++++++++
 tb/tb_emax_blk_arb.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/emax_pkg.sv
// rtl/emax_pkg.sv - shared sizing helpers and arbiter state type for the emax datapath
package emax_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  function automatic int fpblk_sz(input int dim);
    return 1 << (2 * dim);
  endfunction

  function automatic int id_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rvfifo_cc.sv
// rtl/rvfifo_cc.sv - single-clock ready/valid fifo; a full queue refuses push even when popping
module rvfifo_cc #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] s_port_data,
  input  logic         s_port_valid,
  output logic         s_port_ready,
  output logic [W-1:0] m_port_data,
  output logic         m_port_valid,
  input  logic         m_port_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign s_port_ready = (count != CW'(DEPTH));
  assign m_port_valid = (count != '0);
  assign m_port_data  = mem[rd_ptr];
  assign push         = s_port_valid && s_port_ready;
  assign pop          = m_port_valid && m_port_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s_port_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/emax_blk_arb.sv
// rtl/emax_blk_arb.sv - block-granular round-robin arbiter feeding one find_emax from N fp streams
module emax_blk_arb
  import emax_pkg::*;
#(
  parameter int FP        = 32,
  parameter int DIM       = 2,
  parameter int N         = 4,
  parameter int TAG_DEPTH = 4,
  localparam int ID_W     = id_w(N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N*FP-1:0]   s_fp_data,
  input  logic [N-1:0]      s_fp_valid,
  output logic [N-1:0]      s_fp_ready,
  output logic [FP-1:0]     m_fp_data,
  output logic              m_fp_valid,
  input  logic              m_fp_ready,
  output logic [ID_W-1:0]   m_tag_data,
  output logic              m_tag_valid,
  input  logic              m_tag_ready
);

  localparam int BLK   = fpblk_sz(DIM);
  localparam int CNT_W = (2 * DIM > 0) ? 2 * DIM : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLK - 1);

  arb_state_t      state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant;
  logic [CNT_W-1:0] cnt;
  logic [ID_W-1:0] win;
  logic [ID_W-1:0] cand;
  logic            found;
  logic            beat;
  logic            tag_push;
  logic            tag_ready;
  logic [FP-1:0]   lane [N];

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign lane[i] = s_fp_data[i*FP +: FP];
  end

  // Search starts one past the last completed grant so every requester gets a turn.
  always_comb begin
    found      = 1'b0;
    win        = '0;
    cand       = '0;
    m_fp_data  = lane[grant];
    m_fp_valid = 1'b0;
    s_fp_ready = '0;
    for (int k = 1; k <= N; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % N);
      if (!found && s_fp_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    if (state == BURST) begin
      m_fp_valid        = s_fp_valid[grant];
      s_fp_ready[grant] = m_fp_ready;
    end
    beat     = m_fp_valid && m_fp_ready;
    tag_push = (state == IDLE) && found;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      rr_ptr <= ID_W'(N - 1);
      grant  <= '0;
      cnt    <= CNT_LAST;
    end else begin
      case (state)
        IDLE: begin
          // The tag is pushed in the same cycle as the grant, so a full queue blocks the grant.
          if (found && tag_ready) begin
            grant <= win;
            cnt   <= CNT_LAST;
            state <= BURST;
          end
        end
        BURST: begin
          if (beat) begin
            if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end else begin
              rr_ptr <= grant;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  rvfifo_cc #(
    .W     (ID_W),
    .DEPTH (TAG_DEPTH)
  ) u_que_tag (
    .clk          (clk),
    .reset        (reset),
    .s_port_data  (win),
    .s_port_valid (tag_push),
    .s_port_ready (tag_ready),
    .m_port_data  (m_tag_data),
    .m_port_valid (m_tag_valid),
    .m_port_ready (m_tag_ready)
  );

endmodule

// File: tb/tb_emax_blk_arb.sv
// tb/tb_emax_blk_arb.sv - self-checking bench for emax_blk_arb (N=3, DIM=1, TAG_DEPTH=2)
module tb_emax_blk_arb;

  localparam int N  = 3;
  localparam int FP = 32;
  localparam int NROWS = 39;

  logic            clk = 1'b0;
  logic            reset;
  logic [N*FP-1:0] s_fp_data;
  logic [N-1:0]    s_fp_valid;
  logic [N-1:0]    s_fp_ready;
  logic [FP-1:0]   m_fp_data;
  logic            m_fp_valid;
  logic            m_fp_ready;
  logic [1:0]      m_tag_data;
  logic            m_tag_valid;
  logic            m_tag_ready;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic       rst;
    logic [2:0] v;
    logic       mr;
    logic       tr;
    logic [2:0] rdy;
    logic       mv;
    logic [1:0] gnt;
    logic       tv;
    logic [1:0] tag;
  } vec_t;

  vec_t        tbl [NROWS];
  logic [31:0] exp_d [$];
  logic [31:0] exp_t [$];
  int          sent [N];

  emax_blk_arb #(
    .FP        (32),
    .DIM       (1),
    .N         (3),
    .TAG_DEPTH (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_fp_data   (s_fp_data),
    .s_fp_valid  (s_fp_valid),
    .s_fp_ready  (s_fp_ready),
    .m_fp_data   (m_fp_data),
    .m_fp_valid  (m_fp_valid),
    .m_fp_ready  (m_fp_ready),
    .m_tag_data  (m_tag_data),
    .m_tag_valid (m_tag_valid),
    .m_tag_ready (m_tag_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] tword(input int i, input int r);
    return {8'(i), 8'(r), 16'hC0DE};
  endfunction

  function automatic logic [31:0] sword(input int i, input int k);
    return {8'(i), 8'hEE, 16'(k)};
  endfunction

  function automatic vec_t mk(input logic rst, input logic [2:0] v, input logic mr, input logic tr,
                              input logic [2:0] rdy, input logic mv, input logic [1:0] gnt,
                              input logic tv, input logic [1:0] tag);
    vec_t x;
    x = '{rst: rst, v: v, mr: mr, tr: tr, rdy: rdy, mv: mv, gnt: gnt, tv: tv, tag: tag};
    return x;
  endfunction

  task automatic fill(input int a, input int b, input vec_t x);
    for (int r = a; r <= b; r++) tbl[r] = x;
  endtask

  initial begin
    reset       = 1'b0;
    s_fp_valid  = '0;
    s_fp_data   = '0;
    m_fp_ready  = 1'b0;
    m_tag_ready = 1'b0;

    // single requester: two blocks with one bubble between, tags 1,1
    fill(0, 0,   mk(1, 3'b010, 1, 1, 3'b000, 0, 0, 0, 0));
    fill(1, 1,   mk(1, 3'b010, 1, 1, 3'b010, 1, 1, 1, 1));
    fill(2, 4,   mk(1, 3'b010, 1, 1, 3'b010, 1, 1, 0, 0));
    fill(5, 5,   mk(1, 3'b010, 1, 1, 3'b000, 0, 0, 0, 0));
    fill(6, 6,   mk(1, 3'b010, 1, 1, 3'b010, 1, 1, 1, 1));
    fill(7, 9,   mk(1, 3'b010, 1, 1, 3'b010, 1, 1, 0, 0));
    // tag consumer stalled: two grants fill the queue, third withheld until a pop
    fill(10, 10, mk(1, 3'b111, 1, 0, 3'b000, 0, 0, 0, 0));
    fill(11, 14, mk(1, 3'b111, 1, 0, 3'b100, 1, 2, 1, 2));
    fill(15, 15, mk(1, 3'b111, 1, 0, 3'b000, 0, 0, 1, 2));
    fill(16, 19, mk(1, 3'b111, 1, 0, 3'b001, 1, 0, 1, 2));
    fill(20, 21, mk(1, 3'b111, 1, 0, 3'b000, 0, 0, 1, 2));
    fill(22, 22, mk(1, 3'b111, 1, 1, 3'b000, 0, 0, 1, 2));
    fill(23, 23, mk(1, 3'b111, 1, 0, 3'b000, 0, 0, 1, 0));
    // granted requester drops valid mid-block; others stay valid but must wait
    fill(24, 25, mk(1, 3'b111, 1, 0, 3'b010, 1, 1, 1, 0));
    fill(26, 28, mk(1, 3'b101, 1, 0, 3'b010, 0, 1, 1, 0));
    fill(29, 29, mk(1, 3'b111, 0, 0, 3'b000, 1, 1, 1, 0));
    fill(30, 31, mk(1, 3'b111, 1, 0, 3'b010, 1, 1, 1, 0));
    fill(32, 32, mk(1, 3'b111, 1, 1, 3'b000, 0, 0, 1, 0));
    fill(33, 33, mk(1, 3'b111, 1, 1, 3'b000, 0, 0, 1, 1));
    fill(34, 35, mk(1, 3'b111, 1, 0, 3'b100, 1, 2, 1, 2));
    // reset mid-block: queue flushed, requester 0 wins first afterwards
    fill(36, 36, mk(0, 3'b111, 1, 0, 3'b100, 1, 2, 1, 2));
    fill(37, 37, mk(1, 3'b111, 1, 1, 3'b000, 0, 0, 0, 0));
    fill(38, 38, mk(1, 3'b111, 1, 1, 3'b001, 1, 0, 1, 0));

    repeat (3) @(negedge clk);
    s_fp_valid = 3'b111;
    #1;
    chk("reset_s_fp_ready", 32'(s_fp_ready), 32'd0);
    chk("reset_m_fp_valid", 32'(m_fp_valid), 32'd0);
    chk("reset_m_tag_valid", 32'(m_tag_valid), 32'd0);

    for (int r = 0; r < NROWS; r++) begin
      @(negedge clk);
      reset       = tbl[r].rst;
      s_fp_valid  = tbl[r].v;
      m_fp_ready  = tbl[r].mr;
      m_tag_ready = tbl[r].tr;
      for (int i = 0; i < N; i++) s_fp_data[i*FP +: FP] = tword(i, r);
      #1;
      chk($sformatf("row%0d s_fp_ready", r), 32'(s_fp_ready), 32'(tbl[r].rdy));
      chk($sformatf("row%0d m_fp_valid", r), 32'(m_fp_valid), 32'(tbl[r].mv));
      chk($sformatf("row%0d m_tag_valid", r), 32'(m_tag_valid), 32'(tbl[r].tv));
      if (tbl[r].mv) chk($sformatf("row%0d m_fp_data", r), m_fp_data, tword(int'(tbl[r].gnt), r));
      if (tbl[r].tv) chk($sformatf("row%0d m_tag_data", r), 32'(m_tag_data), 32'(tbl[r].tag));
    end

    // scoreboard: all requesters streaming two blocks each, m_fp_ready toggling 1010
    @(negedge clk);
    reset = 1'b0;
    s_fp_valid = '0;
    @(negedge clk);
    reset = 1'b1;
    for (int b = 0; b < 6; b++) begin
      for (int j = 0; j < 4; j++) exp_d.push_back(sword(b % 3, (b / 3) * 4 + j));
      exp_t.push_back(32'(b % 3));
    end
    for (int i = 0; i < N; i++) sent[i] = 0;

    begin
      int cyc;
      cyc = 0;
      while ((exp_d.size() > 0 || exp_t.size() > 0) && cyc < 400) begin
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
          s_fp_valid[i]         = (sent[i] < 8);
          s_fp_data[i*FP +: FP] = sword(i, sent[i]);
        end
        m_fp_ready  = (cyc % 2 == 0);
        m_tag_ready = 1'($urandom_range(0, 1));
        #1;
        chk("sb_ready_onehot", 32'($countones(s_fp_ready) <= 1), 32'd1);
        if (m_fp_valid && m_fp_ready) begin
          if (exp_d.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_extra_beat actual=%h expected=none", m_fp_data);
          end else begin
            chk("sb_beat_data", m_fp_data, exp_d.pop_front());
          end
        end
        if (m_tag_valid && m_tag_ready) begin
          if (exp_t.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_extra_tag actual=%0d expected=none", m_tag_data);
          end else begin
            chk("sb_tag", 32'(m_tag_data), exp_t.pop_front());
          end
        end
        for (int i = 0; i < N; i++) if (s_fp_valid[i] && s_fp_ready[i]) sent[i]++;
        cyc++;
      end
    end
    chk("sb_drained", 32'(exp_d.size() + exp_t.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
